stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised successor of the team's combinational 4:1 mux.
- N-channel, DATA_W-wide registered stream multiplexer with valid/ready handshakes on every input and on the single output.
- Two modes, selected at run time: explicit channel select (sel port), or round-robin arbitration among requesting channels.
- Sits between multiple producer streams and one shared consumer.

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- DATA_W, 2: data width per channel, >=1.
- SEL_W, derived localparam = max(1, clog2(NUM_CH)): width of sel and out_ch.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = select mode (sel), 1 = round-robin mode.
- sel  input  SEL_W  channel index used in select mode.
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready.
- in_data  input  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  DATA_W  registered data.
- out_ch  output  SEL_W  source channel of out_data.
- sel_err  output  1  sticky out-of-range-sel flag (MUX_OOR_ERR_EN only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync deassert by the integrator): out_valid=0, out_data=0, out_ch=0, rr_ptr=0, sel_err=0.
- can_load = !out_valid || out_ready. Output is a single register stage: latency 1 cycle, throughput 1 beat/cycle.
- Grant g, combinational each cycle:
  - Select mode: g = sel. If sel >= NUM_CH, g = NUM_CH-1 (the "else" channel, matching legacy 4:1 mux semantics). Grant is valid regardless of in_valid.
  - Round-robin mode: g = first i with in_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_CH. No grant if no in_valid.
- in_ready[g] = can_load (only when a grant exists); every other in_ready bit = 0.
- Transfer occurs when in_valid[g] && in_ready[g]. On the next edge: out_valid=1, out_data=in_data[g], out_ch=g.
- Drain without refill (out_valid && out_ready && no transfer): out_valid=0. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_valid, out_data and out_ch held stable. All in_ready=0.
- rr_ptr updates only on a transfer made in round-robin mode: rr_ptr = (g+1) mod NUM_CH, wrapping NUM_CH-1 -> 0. Unchanged in select mode.
- mode and sel are sampled every cycle with no latching. A change affects only the next grant and never disturbs a held output beat.
- Simultaneous drain and load in the same cycle: new beat replaces old; out_valid stays 1, so there is no bubble.
- Reset asserted mid-stall: the pending beat is discarded; all outputs return to their reset values immediately.
- Input handshake rule: the block never drops a beat for which in_valid && in_ready was seen.

Optional Feature:
- MUX_OOR_ERR_EN defined:
  - In select mode, when sel >= NUM_CH and any in_valid bit is 1, sel_err sets to 1 on the next edge. It is sticky until reset.
  - Clamping to NUM_CH-1 still applies.
- Undefined: sel_err is constant 0 and no error logic is generated.
- The macro has no effect when NUM_CH is a power of two, because sel cannot be out of range.

Decomposition:
- Package stream_mux_pkg:
  - mode constants MODE_SEL=1'b0, MODE_RR=1'b1
  - clog2-based width helper function
- Sub-module rr_arbiter:
  - parameter NUM_CH
  - inputs req[NUM_CH], ptr[SEL_W]
  - outputs gnt_vld, gnt_idx[SEL_W]
  - purely combinational rotate-priority search
- rr_ptr register and the output register live in stream_mux_arb.

Test Plan:
- Select mode, NUM_CH=4, DATA_W=2, sel=2, in_valid=4'b1111, in_data ch2=2'b10, out_ready=1 -> next cycle out_valid=1, out_data=2'b10, out_ch=2; in_ready=4'b0100.
- Round-robin, all 4 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- Round-robin, only ch1 and ch3 valid, rr_ptr=2 -> ch3 granted first, then ch1, then ch3.
- Backpressure: out_ready=0 for 3 cycles after a beat loads -> out_data and out_ch stable; in_ready=0 all 3 cycles; beat accepted when out_ready=1; no input beat lost or duplicated.
- NUM_CH=3, sel=3, in_valid=3'b111 -> channel 2 forwarded. With MUX_OOR_ERR_EN, sel_err=1 next cycle and stays 1. Without the macro, sel_err stays 0.
- Async reset asserted while out_valid=1 and stalled -> out_valid=0, out_ch=0 and rr_ptr=0 immediately. After release, round-robin starts from ch0.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and width helper for the stream multiplexer/arbiter.
// Imported by the interface, the round-robin arbiter and the top.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width for n channels, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Producer/consumer handshake bundle for stream_mux_arb.
// The slave modport is the mux side; the master modport is the environment side.
interface stream_mux_arb_if
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2,
  parameter int SEL_W  = idx_width(NUM_CH)
);
  // Handshake: a beat moves when valid and ready are both high at a rising edge.
  // valid never waits on ready; ready may depend combinationally on valid.
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     sel_err;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, sel_err
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, sel_err
  );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr,
// wrapping modulo NUM_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_vld,
  output logic [SEL_W-1:0]  gnt_idx
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream mux with run-time select or round-robin mode.
// Define MUX_OOR_ERR_EN to build the sticky out-of-range sel flag (sel_err).
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 2,
  localparam int SEL_W  = idx_width(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_mux_arb_if.slave    bus,
  output logic [SEL_W-1:0]   rr_ptr_o
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic              rr_gnt_vld;
  logic [SEL_W-1:0]  rr_gnt_idx;
  logic [SEL_W-1:0]  sel_clamped;
  logic              gnt_vld;
  logic [SEL_W-1:0]  gnt_idx;
  logic              can_load;
  logic              xfer;
  logic [NUM_CH-1:0] in_ready_d;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .gnt_vld (rr_gnt_vld),
    .gnt_idx (rr_gnt_idx)
  );

  // Out-of-range sel falls through to the last channel, like the legacy mux default.
  always_comb begin
    sel_clamped = (32'(bus.sel) >= NUM_CH) ? LAST_CH : bus.sel;
    if (bus.mode == MODE_RR) begin
      gnt_vld = rr_gnt_vld;
      gnt_idx = rr_gnt_idx;
    end else begin
      gnt_vld = 1'b1;
      gnt_idx = sel_clamped;
    end
  end

  always_comb begin
    can_load   = !out_valid_q || bus.out_ready;
    in_ready_d = '0;
    if (gnt_vld && can_load) in_ready_d[gnt_idx] = 1'b1;
    xfer       = gnt_vld && can_load && bus.in_valid[gnt_idx];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(gnt_idx)*DATA_W +: DATA_W];
      out_ch_d    = gnt_idx;
      if (bus.mode == MODE_RR) rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef MUX_OOR_ERR_EN
  logic sel_oor;
  logic sel_err_q;

  assign sel_oor = (32'(bus.sel) >= NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (bus.mode == MODE_SEL && sel_oor && |bus.in_valid) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: directed scenarios plus randomized
// traffic against a cycle-level reference model and an expected-beat queue.
module tb_stream_mux_arb;
  import stream_mux_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 2;
  localparam int SW  = idx_width(N);
  localparam int N3  = 3;
  localparam int SW3 = idx_width(N3);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.NUM_CH(N),  .DATA_W(DW)) bus  ();
  stream_mux_arb_if #(.NUM_CH(N3), .DATA_W(DW)) bus3 ();
  logic [SW-1:0]  rr_ptr;
  logic [SW3-1:0] rr_ptr3;

  stream_mux_arb #(.NUM_CH(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .rr_ptr_o(rr_ptr)
  );

  stream_mux_arb #(.NUM_CH(N3), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .rr_ptr_o(rr_ptr3)
  );

`ifdef MUX_OOR_ERR_EN
  localparam logic EXP_SEL_ERR = 1'b1;
`else
  localparam logic EXP_SEL_ERR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state for the 4-channel instance.
  bit                m_valid;
  logic [DW-1:0]     m_data;
  int                m_ch;
  int                m_ptr;
  logic [N-1:0]      m_rdy;
  logic [DW+SW-1:0]  exp_q[$];

  function automatic int model_grant(input logic md, input int s, input logic [N-1:0] v, input int ptr);
    if (md == MODE_SEL) return (s >= N) ? N - 1 : s;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_ptr   = 0;
    m_rdy   = '0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int g;
    bit cl;
    cl = !m_valid || bus.out_ready;
    g  = model_grant(bus.mode, int'(bus.sel), bus.in_valid, m_ptr);
    m_rdy = '0;
    if (g >= 0 && cl) m_rdy[g] = 1'b1;
    if (m_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (g >= 0 && cl && bus.in_valid[g]) begin
      m_valid = 1'b1;
      m_data  = bus.in_data[g*DW +: DW];
      m_ch    = g;
      if (bus.mode == MODE_RR) m_ptr = (g + 1) % N;
      exp_q.push_back({m_data, SW'(g)});
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    checks++; if (bus.out_ch !== '0) begin errors++; $display("FAIL reset_out_ch: got %0d expected 0", bus.out_ch); end
    checks++; if (rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", rr_ptr); end
    checks++; if (bus.sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %0b expected 0", bus.sel_err); end
    checks++; if (bus3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid3: got %0b expected 0", bus3.out_valid); end
  endtask

  task automatic test_select();
    logic [N*DW-1:0] d;
    d = (N*DW)'($urandom);
    d[2*DW +: DW] = 2'b10;
    bus.mode = MODE_SEL; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.in_data = d; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL select_in_ready: got %b expected 0100", bus.in_ready); end
    model_step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL select_out_valid: got %0b expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 2'b10) begin errors++; $display("FAIL select_out_data: got %b expected 10", bus.out_data); end
    checks++; if (bus.out_ch !== 2'd2) begin errors++; $display("FAIL select_out_ch: got %0d expected 2", bus.out_ch); end
    checks++; if (rr_ptr !== '0) begin errors++; $display("FAIL select_rr_ptr: got %0d expected 0", rr_ptr); end
  endtask

  task automatic test_rr_all();
    logic [DW-1:0] sent;
    bus.mode = MODE_RR; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_data = (N*DW)'($urandom);
      sent = bus.in_data[(k % N)*DW +: DW];
      #1;
      checks++; if (bus.in_ready !== N'(1 << (k % N))) begin errors++; $display("FAIL rr_all_in_ready[%0d]: got %b expected %b", k, bus.in_ready, N'(1 << (k % N))); end
      model_step();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== SW'(k % N) || bus.out_data !== sent) begin
        errors++; $display("FAIL rr_all_beat[%0d]: got v=%0b ch=%0d d=%0h expected v=1 ch=%0d d=%0h", k, bus.out_valid, bus.out_ch, bus.out_data, k % N, sent);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch[3] = '{3, 1, 3};
    bus.mode = MODE_RR; bus.in_valid = 4'b0010; bus.out_ready = 1'b1; bus.in_data = (N*DW)'($urandom);
    #1; model_step();
    @(negedge clk);
    checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_sparse_ptr_setup: got %0d expected 2", rr_ptr); end
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      bus.in_data = (N*DW)'($urandom);
      #1; model_step();
      @(negedge clk);
      checks++; if (bus.out_ch !== SW'(exp_ch[k]) || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_sparse_ch[%0d]: got v=%0b ch=%0d expected v=1 ch=%0d", k, bus.out_valid, bus.out_ch, exp_ch[k]);
      end
    end
    checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rr_sparse_ptr_end: got %0d expected 0", rr_ptr); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held_d;
    logic [SW-1:0] held_ch;
    bus.mode = MODE_RR; bus.in_valid = 4'b1111; bus.out_ready = 1'b1; bus.in_data = (N*DW)'($urandom);
    held_d  = bus.in_data[m_ptr*DW +: DW];
    held_ch = SW'(m_ptr);
    #1; model_step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.out_ready = 1'b0; bus.in_data = (N*DW)'($urandom);
      #1;
      checks++; if (bus.in_ready !== '0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, bus.in_ready); end
      model_step();
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== held_d || bus.out_ch !== held_ch) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%0b d=%0h ch=%0d expected v=1 d=%0h ch=%0d", k, bus.out_valid, bus.out_data, bus.out_ch, held_d, held_ch);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (exp_q.size() != 1 || exp_q[0] !== {bus.out_data, bus.out_ch}) begin
      errors++; $display("FAIL bp_scoreboard: got depth=%0d beat=%0h expected depth=1 beat=%0h", exp_q.size(), {bus.out_data, bus.out_ch}, {held_d, held_ch});
    end
    model_step();
    checks++; if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", bus.in_ready, m_rdy); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== SW'(m_ch) || bus.out_data !== m_data) begin
      errors++; $display("FAIL bp_next_beat: got ch=%0d d=%0h expected ch=%0d d=%0h", bus.out_ch, bus.out_data, m_ch, m_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.mode      = logic'($urandom_range(0, 1));
      bus.sel       = SW'($urandom_range(0, N - 1));
      bus.in_valid  = N'($urandom_range(0, (1 << N) - 1));
      bus.in_data   = (N*DW)'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (exp_q.size() == 0 || exp_q[0] !== {bus.out_data, bus.out_ch}) begin
          errors++; $display("FAIL rnd_consumed_beat[%0d]: got %0h expected depth>0 front=%0h", i, {bus.out_data, bus.out_ch}, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
      end
      model_step();
      checks++; if (bus.in_ready !== m_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, bus.in_ready, m_rdy); end
      @(negedge clk);
      checks++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_ch !== SW'(m_ch)) begin
        errors++; $display("FAIL rnd_out[%0d]: got v=%0b d=%0h ch=%0d expected v=%0b d=%0h ch=%0d", i, bus.out_valid, bus.out_data, bus.out_ch, m_valid, m_data, m_ch);
      end
      checks++; if (rr_ptr !== SW'(m_ptr) || bus.sel_err !== 1'b0) begin
        errors++; $display("FAIL rnd_ptr_err[%0d]: got ptr=%0d err=%0b expected ptr=%0d err=0", i, rr_ptr, bus.sel_err, m_ptr);
      end
    end
  endtask

  task automatic test_oor();
    logic [N3*DW-1:0] d;
    d = (N3*DW)'($urandom);
    bus3.mode = MODE_SEL; bus3.sel = 2'd3; bus3.in_valid = 3'b111; bus3.in_data = d; bus3.out_ready = 1'b1;
    #1;
    checks++; if (bus3.in_ready !== 3'b100) begin errors++; $display("FAIL oor_in_ready: got %b expected 100", bus3.in_ready); end
    checks++; if (bus3.sel_err !== 1'b0) begin errors++; $display("FAIL oor_err_before_edge: got %0b expected 0", bus3.sel_err); end
    @(negedge clk);
    checks++; if (bus3.out_valid !== 1'b1 || bus3.out_ch !== 2'd2 || bus3.out_data !== d[2*DW +: DW]) begin
      errors++; $display("FAIL oor_forward: got v=%0b ch=%0d d=%0h expected v=1 ch=2 d=%0h", bus3.out_valid, bus3.out_ch, bus3.out_data, d[2*DW +: DW]);
    end
    checks++; if (bus3.sel_err !== EXP_SEL_ERR) begin errors++; $display("FAIL oor_sel_err: got %0b expected %0b", bus3.sel_err, EXP_SEL_ERR); end
    bus3.sel = 2'd0; bus3.in_valid = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus3.sel_err !== EXP_SEL_ERR) begin errors++; $display("FAIL oor_sel_err_sticky: got %0b expected %0b", bus3.sel_err, EXP_SEL_ERR); end
  endtask

  task automatic test_reset_midstall();
    bus.mode = MODE_RR; bus.in_valid = '0; bus.out_ready = 1'b1;
    #1; model_step();
    @(negedge clk);
    bus.in_valid = 4'b0010; bus.out_ready = 1'b0; bus.in_data = (N*DW)'($urandom);
    #1; model_step();
    @(negedge clk);
    #1; model_step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1 || rr_ptr !== 2'd2) begin
      errors++; $display("FAIL midstall_setup: got v=%0b ch=%0d ptr=%0d expected v=1 ch=1 ptr=2", bus.out_valid, bus.out_ch, rr_ptr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_data !== '0 || rr_ptr !== '0) begin
      errors++; $display("FAIL midstall_reset: got v=%0b ch=%0d d=%0h ptr=%0d expected all 0", bus.out_valid, bus.out_ch, bus.out_data, rr_ptr);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 4'b1111; bus.out_ready = 1'b1; bus.in_data = (N*DW)'($urandom);
    #1; model_step();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd0 || bus.out_data !== m_data) begin
      errors++; $display("FAIL midstall_restart: got v=%0b ch=%0d d=%0h expected v=1 ch=0 d=%0h", bus.out_valid, bus.out_ch, bus.out_data, m_data);
    end
  endtask

  initial begin
    bus.mode = MODE_SEL; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus3.mode = MODE_SEL; bus3.sel = '0; bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_select();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_random();
    test_oor();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
